// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI responder with configurable word size, clock phases and bit order
module spi_slave #(
    parameter int WordWidth  = 8,
    parameter int IndexWidth = 3,
    parameter bit SPOL       = 1'b0,
    parameter bit CPOL       = 1'b0,
    parameter bit MOSI_PHA   = 1'b0,
    parameter bit MISO_PHA   = 1'b0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IndexWidth-1:0] nbits_m1,
    input  logic [WordWidth-1:0]  tx_word,
    input  logic                  tx_valid,
    output logic                  tx_accepted,
    output logic                  tx_underrun,
    output logic [WordWidth-1:0]  rx_word,
    output logic                  rx_valid,
    output logic                  busy,
    input  logic                  sclk,
    input  logic                  ssel,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_next;
    logic [2:0] sclk_s;
    logic [1:0] ssel_s, mosi_s;
    logic [WordWidth-1:0] tx_sh, rx_sh, rx_next, tx_load;
    logic [IndexWidth-1:0] tx_cnt, rx_cnt, tx_nb, rx_nb;
    logic ssel_on, lead, lag, sample, shift, start;

    // bring the SPI pins into the clk domain; the third sclk flop feeds edge detection
    always_ff @(posedge clk)
        if (reset) begin
            sclk_s <= {3{CPOL}};
            ssel_s <= {2{~SPOL}};
            mosi_s <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], sclk};
            ssel_s <= {ssel_s[0], ssel};
            mosi_s <= {mosi_s[0], mosi};
        end

    // state register
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_next;

    // next state, edge qualification and combinational outputs
    always_comb begin
        ssel_on = ssel_s[1] == SPOL;
        state_next = ssel_on ? ACTIVE : IDLE;
        start = state == IDLE && ssel_on;
        lead = state == ACTIVE && ssel_on && sclk_s[2] == CPOL && sclk_s[1] != CPOL;
        lag = state == ACTIVE && ssel_on && sclk_s[2] != CPOL && sclk_s[1] == CPOL;
        sample = MOSI_PHA ? lag : lead;
        shift = MISO_PHA ? lead : lag;
        busy = state == ACTIVE;
        miso_oe = state == ACTIVE;
        tx_load = tx_valid ? tx_word : '0;
        rx_next = MSB_FIRST ? {rx_sh[WordWidth-2:0], mosi_s[1]}
                            : (rx_sh >> 1) | (WordWidth'(mosi_s[1]) << rx_nb);
        miso = MSB_FIRST ? tx_sh[tx_nb] : tx_sh[0];
    end

    // shifters, bit counters and handshake pulses; a tx counter of zero on a shift edge means reload
    always_ff @(posedge clk)
        if (reset) begin
            tx_sh <= '0;
            rx_sh <= '0;
            tx_cnt <= '0;
            rx_cnt <= '0;
            tx_nb <= '0;
            rx_nb <= '0;
            rx_word <= '0;
            rx_valid <= 1'b0;
            tx_accepted <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_accepted <= 1'b0;
            tx_underrun <= 1'b0;
            rx_valid <= 1'b0;
            if (state == IDLE) begin
                rx_sh <= '0;
                rx_cnt <= start ? nbits_m1 : '0;
                rx_nb <= start ? nbits_m1 : '0;
                tx_nb <= start ? nbits_m1 : '0;
                tx_cnt <= start && !MISO_PHA ? nbits_m1 : '0;
                tx_sh <= start && !MISO_PHA ? tx_load : '0;
                tx_accepted <= start && !MISO_PHA && tx_valid;
                tx_underrun <= start && !MISO_PHA && !tx_valid;
            end else begin
                if (sample) begin
                    rx_sh <= rx_cnt == '0 ? '0 : rx_next;
                    rx_cnt <= rx_cnt == '0 ? nbits_m1 : rx_cnt - 1'b1;
                    if (rx_cnt == '0) begin
                        rx_word <= rx_next;
                        rx_valid <= 1'b1;
                        rx_nb <= nbits_m1;
                    end
                end
                if (shift) begin
                    tx_sh <= tx_cnt == '0 ? tx_load : (MSB_FIRST ? tx_sh << 1 : tx_sh >> 1);
                    tx_cnt <= tx_cnt == '0 ? nbits_m1 : tx_cnt - 1'b1;
                    if (tx_cnt == '0) begin
                        tx_nb <= nbits_m1;
                        tx_accepted <= tx_valid;
                        tx_underrun <= !tx_valid;
                    end
                end
            end
        end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: sixteen slaves (every CPOL/MOSI_PHA/MISO_PHA/MSB_FIRST mix) driven by one SPI master model
module tb_spi_slave;
    localparam int N = 16;
    localparam int HALF = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] nbits_m1 = 3'd7;
    logic ss = 1'b1;
    logic ph = 1'b0;
    int lead_cnt = 0, lag_cnt = 0, nb_v = 7;
    logic [31:0] mw_all = '0;
    logic [7:0] tx_list [4];
    int tx_n = 0;
    int tx_rd [N];
    logic [7:0] tx_word_a [N];
    logic [7:0] rx_word_a [N];
    logic tx_valid_a [N], tx_accepted_a [N], tx_underrun_a [N], rx_valid_a [N];
    logic busy_a [N], miso_a [N], miso_oe_a [N], sclk_a [N], mosi_a [N];
    logic [7:0] exp_rx [$];
    int rx_idx [N], acc_n [N], und_n [N], cap_n [N];
    logic cap [N][64];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    function automatic logic bit_at(input int idx, input bit msb, input int nb, input logic [31:0] w);
        int p;
        if (idx < 0 || idx >= 4 * (nb + 1)) return 1'b0;
        p = idx % (nb + 1);
        return w[(idx / (nb + 1)) * 8 + (msb ? nb - p : p)];
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam bit CP = (g & 1) != 0;
        localparam bit MP = (g & 2) != 0;
        localparam bit SP = (g & 4) != 0;
        localparam bit MSB = (g & 8) == 0;
        assign sclk_a[g] = ph ^ CP;
        assign mosi_a[g] = bit_at(MP ? lead_cnt - 1 : lag_cnt, MSB, nb_v, mw_all);
        assign tx_valid_a[g] = tx_rd[g] < tx_n;
        assign tx_word_a[g] = tx_rd[g] < tx_n ? tx_list[tx_rd[g][1:0]] : 8'h00;
        spi_slave #(
            .WordWidth(8), .IndexWidth(3), .SPOL(1'b0), .CPOL(CP),
            .MOSI_PHA(MP), .MISO_PHA(SP), .MSB_FIRST(MSB)
        ) dut (
            .clk(clk), .reset(reset), .nbits_m1(nbits_m1),
            .tx_word(tx_word_a[g]), .tx_valid(tx_valid_a[g]),
            .tx_accepted(tx_accepted_a[g]), .tx_underrun(tx_underrun_a[g]),
            .rx_word(rx_word_a[g]), .rx_valid(rx_valid_a[g]), .busy(busy_a[g]),
            .sclk(sclk_a[g]), .ssel(ss), .mosi(mosi_a[g]),
            .miso(miso_a[g]), .miso_oe(miso_oe_a[g])
        );
    end

    task automatic check(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0h exp=%0h", name, i, got, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (tx_accepted_a[i]) begin
                    acc_n[i]++;
                    tx_rd[i]++;
                end
                if (tx_underrun_a[i]) und_n[i]++;
                if (rx_valid_a[i]) begin
                    if (rx_idx[i] < exp_rx.size()) check("rx_word", i, rx_word_a[i], exp_rx[rx_idx[i]]);
                    else check("rx_extra_valid", i, rx_idx[i] + 1, exp_rx.size());
                    rx_idx[i]++;
                end
            end
        end
    endtask

    task automatic sample_miso(input bit lagging);
        for (int i = 0; i < N; i++)
            if (i[2] == lagging) begin
                cap[i][cap_n[i]] = miso_a[i];
                cap_n[i]++;
            end
    endtask

    task automatic xfer(input int nbm1, input logic [31:0] words, input int nsent, input int rst_bit);
        @(negedge clk);
        nbits_m1 = 3'(nbm1);
        nb_v = nbm1;
        mw_all = words;
        lead_cnt = 0;
        lag_cnt = 0;
        for (int i = 0; i < N; i++) begin
            cap_n[i] = 0;
            rx_idx[i] = 0;
            acc_n[i] = 0;
            und_n[i] = 0;
            tx_rd[i] = 0;
        end
        ss = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < nsent; b++) begin
            if (b == rst_bit) begin
                reset = 1'b1;
                @(negedge clk);
                for (int i = 0; i < N; i++)
                    check("reset_outputs", i, {busy_a[i], miso_oe_a[i], rx_valid_a[i]}, 3'b000);
                reset = 1'b0;
            end
            if (b == 1 && rst_bit < 0)
                for (int i = 0; i < N; i++) check("busy_active", i, {busy_a[i], miso_oe_a[i]}, 2'b11);
            sample_miso(1'b0);
            ph = 1'b1;
            lead_cnt++;
            repeat (HALF) @(negedge clk);
            sample_miso(1'b1);
            ph = 1'b0;
            lag_cnt++;
            repeat (HALF) @(negedge clk);
        end
        repeat (HALF) @(negedge clk);
        ss = 1'b1;
        repeat (12) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("idle_busy", i, {busy_a[i], miso_oe_a[i]}, 2'b00);
            check("rx_count", i, rx_idx[i], exp_rx.size());
        end
    endtask

    task automatic check_tx(input int nw, input int nbm1, input logic [15:0] exp_words,
                            input int acc0, input int acc1, input int und0, input int und1);
        logic [7:0] got;
        for (int i = 0; i < N; i++) begin
            for (int w = 0; w < nw; w++) begin
                got = '0;
                for (int p = 0; p <= nbm1; p++)
                    got[i[3] ? p : nbm1 - p] = cap[i][w * (nbm1 + 1) + p];
                check("miso_word", i, got, exp_words[w * 8 +: 8]);
            end
            if (acc0 >= 0) check("tx_accepted_count", i, acc_n[i], i[2] ? acc1 : acc0);
            if (und0 >= 0) check("tx_underrun_count", i, und_n[i], i[2] ? und1 : und0);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        repeat (4) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("reset_flags", i, {busy_a[i], miso_oe_a[i], rx_valid_a[i], miso_a[i],
                                     tx_accepted_a[i], tx_underrun_a[i]}, 6'b0);
            check("reset_rx_word", i, rx_word_a[i], 8'h00);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        exp_rx.delete(); exp_rx.push_back(8'h3C);
        tx_list[0] = 8'hA5; tx_n = 1;
        xfer(7, 32'h3C, 8, -1);
        check_tx(1, 7, 16'h00A5, 1, 1, -1, -1);
        exp_rx.delete(); exp_rx.push_back(8'h81);
        tx_list[0] = 8'h5E; tx_n = 1;
        xfer(7, 32'h81, 8, -1);
        check_tx(1, 7, 16'h005E, 1, 1, -1, -1);
        exp_rx.delete(); exp_rx.push_back(8'h5E);
        tx_list[0] = 8'h81; tx_n = 1;
        xfer(7, 32'h5E, 8, -1);
        check_tx(1, 7, 16'h0081, 1, 1, -1, -1);
        exp_rx.delete(); exp_rx.push_back(8'h12); exp_rx.push_back(8'h34);
        tx_list[0] = 8'hAB; tx_list[1] = 8'hCD; tx_n = 2;
        xfer(7, 32'h3412, 16, -1);
        check_tx(2, 7, 16'hCDAB, 2, 2, -1, -1);
        exp_rx.delete(); exp_rx.push_back(8'h0B);
        tx_list[0] = 8'h06; tx_n = 1;
        xfer(3, 32'h0B, 4, -1);
        check_tx(1, 3, 16'h0006, 1, 1, -1, -1);
        exp_rx.delete(); exp_rx.push_back(8'h3C);
        tx_n = 0;
        xfer(7, 32'h3C, 8, -1);
        check_tx(1, 7, 16'h0000, 0, 0, 2, 1);
        exp_rx.delete();
        tx_list[0] = 8'hA5; tx_n = 1;
        xfer(7, 32'hFF, 3, -1);
        exp_rx.delete();
        xfer(7, 32'h55, 8, 2);
        exp_rx.delete(); exp_rx.push_back(8'hC3);
        tx_list[0] = 8'h96; tx_n = 1;
        xfer(7, 32'hC3, 8, -1);
        check_tx(1, 7, 16'h0096, 1, 1, -1, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
